lz77_stream_encoder: RTL and testbench
======================================

# lz77_stream_encoder

Parametrised LZ77 encoder with valid/ready handshakes on both sides. It takes a character stream terminated by an explicit `in_last` flag, keeps a sliding search buffer and a lookahead buffer, and emits (offset, match length, next char) triples. It is the configurable, back-pressure-capable successor to the fixed 9/8-depth encoder and sits between the character source and the triple packer/decoder path.

## Interface
- `SB_DEPTH`, default 9: search buffer entries (≥2).
- `LA_DEPTH`, default 8: lookahead buffer entries (≥2).
- `CHAR_W`, default 8: character width.
- `OFF_W` = $clog2(SB_DEPTH), derived (default 4); `LEN_W` = $clog2(LA_DEPTH), derived (default 3).
- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: `in_char` is valid.
- `in_ready` out 1: encoder accepts a char this cycle.
- `in_char` in CHAR_W: input character.
- `in_last` in 1: this char is the final char of the string.
- `out_valid` out 1: the triple is valid.
- `out_ready` in 1: the consumer accepts the triple.
- `out_offset` out OFF_W: match start distance, where 0 is the most recently encoded char.
- `out_len` out LEN_W: match length.
- `out_char` out CHAR_W: the literal char following the match.
- `out_last` out 1: this triple covers the final input char.
- `done` out 1: one-cycle pulse after the last triple is accepted.

## Operation
- Buffers:
  - `sb[0..SB_DEPTH-1]` is a shift register; `sb[0]` is the newest entry.
  - `sb_cnt` saturates at SB_DEPTH. At saturation the oldest entry is dropped.
  - `la[0..LA_DEPTH-1]` is the lookahead, with count `la_cnt`. A `last_seen` flag is set when a char with `in_last` is accepted.
- States: IDLE, FILL, SEARCH, EMIT, SHIFT.
- IDLE → FILL on the first cycle after reset deasserts.
- FILL:
  - `in_ready` = (`la_cnt` < LA_DEPTH) && !`last_seen`.
  - Each handshake appends to `la[la_cnt]`.
  - → SEARCH when `la_cnt` == LA_DEPTH, or when `last_seen` && `la_cnt` ≥ 1.
  - With no input, FILL waits indefinitely. There is no timeout.
- SEARCH:
  - One candidate offset k per cycle, k = 0 .. SB_DEPTH-1, so SB_DEPTH cycles total.
  - Candidates with k ≥ `sb_cnt` score 0.
  - The match compares the source sequence sb[k], sb[k-1] … sb[0], la[0], la[1] … against la[0], la[1] ….
  - Length cap = `la_cnt`-1. This guarantees `out_char` is always a real input char.
  - Best result = longest match. Ties go to the smallest k.
  - Length 0 forces offset 0.
- EMIT:
  - Presents (best_k, best_len, la[best_len]).
  - `out_last` = `last_seen` && (best_len+1 == `la_cnt`).
  - Holds until `out_ready`, then → SHIFT.
- SHIFT:
  - Moves la[0] into sb[0] and shifts `la` down by one, one char per cycle, for best_len+1 cycles.
  - Afterwards: if `out_last` was sent → IDLE, clear all counts and `last_seen`, and pulse `done`; else → FILL.
- Arithmetic: lengths and counts are unsigned. `la_cnt` needs $clog2(LA_DEPTH+1) bits.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_offset`=0, `out_len`=0, `out_char`=0, `out_last`=0, `done`=0, state IDLE, `sb_cnt`=`la_cnt`=0.
- Reset mid-operation: all partial state is discarded within the same edge. A pending triple is lost.
- `in_ready` is high only in FILL. It is never high while `out_valid` is high.
- `out_valid` rises on the first EMIT cycle. While `out_ready`=0, all `out_*` signals stay stable.
- `out_valid` falls the cycle after the handshake.
- Per-triple latency from the FILL exit to `out_valid` = SB_DEPTH cycles. Throughput ≈ fill + SB_DEPTH + 1 + (len+1) cycles.
- `done` rises the cycle after the final SHIFT and lasts exactly 1 cycle.
- If `in_valid` is asserted with `in_last` on a single-char string: triple (0,0,c) with `out_last`=1.

## Configuration
- `LZ77_OVERLAP_EN` defined: a match may run from sb[0] into the lookahead (self-overlap), as defined in the SEARCH rule.
- `LZ77_OVERLAP_EN` undefined: the length is additionally capped at k+1, so the match source stays inside the search buffer.

## Test plan
All scenarios use default parameters with ASCII hex chars.
- Input "0000", `in_last` on the 4th char, overlap on → (0,0,'0'), then (0,2,'0') with `out_last`=1, then `done` pulses once.
- Same input, overlap off → (0,0,'0'), (0,1,'0'), (0,0,'0') with `out_last`=1.
- Input "01201" → (0,0,'0'), (0,0,'1'), (0,0,'2'), (2,1,'1') with `out_last`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles during the first EMIT → `out_*` signals are constant, `in_ready`=0; the triple completes after release.
- Wrap-around: input of 20 chars "0123456789ABCDEF0123" → the final "0123" match is not found, because the last '0' has been dropped beyond SB_DEPTH=9. The trailing triples equal literal-only encoding for the unmatched chars, and `sb_cnt` stays at 9.
- Assert `reset` during SEARCH → next cycle all outputs are 0; a new string "5" then yields (0,0,'5') with `out_last`=1.

Source files
------------

// File: rtl/lz77_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : lz77_stream_if
//  Description : Character-in / triple-out handshake bundle for the LZ77
//                stream encoder. The slave modport is the encoder side, the
//                master modport is the source/consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lz77_stream_if #(
    parameter int CHAR_W = 8,
    parameter int OFF_W  = 4,
    parameter int LEN_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [CHAR_W-1:0] in_char;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OFF_W-1:0]  out_offset;
    logic [LEN_W-1:0]  out_len;
    logic [CHAR_W-1:0] out_char;
    logic              out_last;
    logic              done;

    modport master (
        output in_valid, in_char, in_last, out_ready,
        input  in_ready, out_valid, out_offset, out_len, out_char, out_last, done
    );

    modport slave (
        input  in_valid, in_char, in_last, out_ready,
        output in_ready, out_valid, out_offset, out_len, out_char, out_last, done
    );
endinterface
`default_nettype wire

// File: rtl/lz77_stream_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : lz77_stream_encoder
//  Description : Parametrised LZ77 encoder. Buffers up to LA_DEPTH chars,
//                scans one search-buffer offset per cycle and emits
//                (offset, length, next char) triples with valid/ready flow.
//                Define LZ77_OVERLAP_EN to let a match run from sb[0] on into
//                the lookahead (self-overlapping match).
//  Revision    : 1.0 - initial release
// ============================================================================
module lz77_stream_encoder #(
    parameter  int SB_DEPTH = 9,
    parameter  int LA_DEPTH = 8,
    parameter  int CHAR_W   = 8,
    localparam int OFF_W    = $clog2(SB_DEPTH),
    localparam int LEN_W    = $clog2(LA_DEPTH)
) (
    input  wire logic    clk,
    input  wire logic    reset,
    lz77_stream_if.slave s
);
    localparam int c_LCNT_W = $clog2(LA_DEPTH + 1);
    localparam int c_SCNT_W = $clog2(SB_DEPTH + 1);
    localparam int c_REM_W  = LEN_W + 1;
    localparam int c_CAT_N  = SB_DEPTH + LA_DEPTH;
    localparam int c_IDX_W  = $clog2(c_CAT_N);
    localparam int c_CAT_P  = 1 << c_IDX_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_SEARCH = 3'd2,
        S_EMIT   = 3'd3,
        S_SHIFT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CHAR_W-1:0]   r_sb [SB_DEPTH];
    logic [CHAR_W-1:0]   r_la [LA_DEPTH];
    logic [c_SCNT_W-1:0] r_sb_cnt;
    logic [c_LCNT_W-1:0] r_la_cnt;
    logic                r_last_seen;
    logic [OFF_W-1:0]    r_k;
    logic [OFF_W-1:0]    r_best_k;
    logic [LEN_W-1:0]    r_best_len;
    logic [c_REM_W-1:0]  r_rem;
    logic                r_last_sent;
    logic                r_done;

    logic [CHAR_W-1:0]   w_cat [c_CAT_P];
    logic [LEN_W-1:0]    w_cand_len;
    logic [CHAR_W-1:0]   w_out_char;
    logic                w_in_ready;
    logic                w_emit;
    logic                w_out_last;

    assign w_emit     = (r_state == S_EMIT);
    assign w_in_ready = (r_state == S_FILL) && (r_la_cnt < c_LCNT_W'(LA_DEPTH)) && !r_last_seen;
    assign w_out_last = r_last_seen && ((int'(r_best_len) + 1) == int'(r_la_cnt));

    assign s.in_ready   = w_in_ready;
    assign s.out_valid  = w_emit;
    assign s.out_offset = w_emit ? r_best_k   : '0;
    assign s.out_len    = w_emit ? r_best_len : '0;
    assign s.out_char   = w_emit ? w_out_char : '0;
    assign s.out_last   = w_emit && w_out_last;
    assign s.done       = r_done;

    // Next-state selection for the fill / search / emit / shift sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   w_state_nxt = S_FILL;
            S_FILL:   if (r_la_cnt == c_LCNT_W'(LA_DEPTH) || (r_last_seen && r_la_cnt != '0))
                          w_state_nxt = S_SEARCH;
            S_SEARCH: if (r_k == OFF_W'(SB_DEPTH - 1)) w_state_nxt = S_EMIT;
            S_EMIT:   if (s.out_ready) w_state_nxt = S_SHIFT;
            S_SHIFT:  if (r_rem == c_REM_W'(1)) w_state_nxt = r_last_sent ? S_IDLE : S_FILL;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Match length for candidate offset r_k. Search buffer (oldest first) and
    // lookahead are laid end to end so the source char for position j is
    // always w_cat[SB_DEPTH-1-k+j], whether it lies in sb or spills into la.
    always_comb begin
        int v_cap;
        int v_len;
        logic v_run;
        for (int i = 0; i < c_CAT_P; i++) w_cat[i] = '0;
        for (int i = 0; i < SB_DEPTH; i++) w_cat[i] = r_sb[SB_DEPTH-1-i];
        for (int i = 0; i < LA_DEPTH; i++) w_cat[SB_DEPTH+i] = r_la[i];
        v_cap = (int'(r_k) < int'(r_sb_cnt)) ? int'(r_la_cnt) - 1 : 0;
`ifdef LZ77_OVERLAP_EN
`else
        if (v_cap > int'(r_k) + 1) v_cap = int'(r_k) + 1;
`endif
        v_len = 0;
        v_run = 1'b1;
        for (int j = 0; j < LA_DEPTH - 1; j++) begin
            if (v_run && j < v_cap && w_cat[c_IDX_W'(SB_DEPTH - 1 - int'(r_k) + j)] == r_la[j])
                v_len = v_len + 1;
            else
                v_run = 1'b0;
        end
        w_cand_len = LEN_W'(v_len);
    end

    // Literal following the best match.
    always_comb begin
        w_out_char = '0;
        for (int i = 0; i < LA_DEPTH; i++)
            if (LEN_W'(i) == r_best_len) w_out_char = r_la[i];
    end

    // State, buffers, search bookkeeping and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < SB_DEPTH; i++) r_sb[i] <= '0;
            for (int i = 0; i < LA_DEPTH; i++) r_la[i] <= '0;
            r_sb_cnt    <= '0;
            r_la_cnt    <= '0;
            r_last_seen <= 1'b0;
            r_k         <= '0;
            r_best_k    <= '0;
            r_best_len  <= '0;
            r_rem       <= '0;
            r_last_sent <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (s.in_valid && w_in_ready) begin
                        for (int i = 0; i < LA_DEPTH; i++)
                            if (c_LCNT_W'(i) == r_la_cnt) r_la[i] <= s.in_char;
                        r_la_cnt <= r_la_cnt + 1'b1;
                        if (s.in_last) r_last_seen <= 1'b1;
                    end
                    r_k        <= '0;
                    r_best_k   <= '0;
                    r_best_len <= '0;
                end
                S_SEARCH: begin
                    // Strictly longer wins, so ties keep the smaller offset.
                    if (w_cand_len > r_best_len) begin
                        r_best_len <= w_cand_len;
                        r_best_k   <= r_k;
                    end
                    r_k <= (r_k == OFF_W'(SB_DEPTH - 1)) ? '0 : r_k + 1'b1;
                end
                S_EMIT: begin
                    if (s.out_ready) begin
                        r_rem       <= {1'b0, r_best_len} + 1'b1;
                        r_last_sent <= w_out_last;
                    end
                end
                S_SHIFT: begin
                    r_sb[0] <= r_la[0];
                    for (int i = 1; i < SB_DEPTH; i++) r_sb[i] <= r_sb[i-1];
                    for (int i = 0; i < LA_DEPTH - 1; i++) r_la[i] <= r_la[i+1];
                    r_la[LA_DEPTH-1] <= '0;
                    r_la_cnt <= r_la_cnt - 1'b1;
                    if (r_sb_cnt != c_SCNT_W'(SB_DEPTH)) r_sb_cnt <= r_sb_cnt + 1'b1;
                    r_rem <= r_rem - 1'b1;
                    if (r_rem == c_REM_W'(1) && r_last_sent) begin
                        r_done      <= 1'b1;
                        r_la_cnt    <= '0;
                        r_sb_cnt    <= '0;
                        r_last_seen <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lz77_stream_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lz77_stream_encoder
//  Description : Self-checking bench for lz77_stream_encoder (default
//                parameters). Expected triples come from a string-level LZ77
//                model; honours LZ77_OVERLAP_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lz77_stream_encoder;
    localparam int c_SB = 9;
    localparam int c_LA = 8;

    typedef struct {
        int off;
        int len;
        int ch;
        int last;
    } trip_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] stim[$];
    trip_t      exp_q[$];

    lz77_stream_if #(.CHAR_W(8), .OFF_W(4), .LEN_W(3)) bus ();

    lz77_stream_encoder #(.SB_DEPTH(c_SB), .LA_DEPTH(c_LA), .CHAR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input string t);
        stim.delete();
        for (int i = 0; i < t.len(); i++) stim.push_back(t[i]);
    endtask

    // Greedy LZ77 over the whole string: the lookahead is the next up to c_LA
    // chars, the search window the previous up to c_SB chars.
    task automatic model();
        int n;
        int pos;
        int la_n;
        int sb_n;
        int bl;
        int bk;
        int cap;
        int l;
        trip_t t;
        n   = stim.size();
        pos = 0;
        exp_q.delete();
        while (pos < n) begin
            la_n = (n - pos < c_LA) ? n - pos : c_LA;
            sb_n = (pos < c_SB) ? pos : c_SB;
            bl = 0;
            bk = 0;
            for (int k = 0; k < sb_n; k++) begin
                cap = la_n - 1;
`ifndef LZ77_OVERLAP_EN
                if (cap > k + 1) cap = k + 1;
`endif
                l = 0;
                while (l < cap && stim[pos - 1 - k + l] == stim[pos + l]) l++;
                if (l > bl) begin
                    bl = l;
                    bk = k;
                end
            end
            t.off  = bk;
            t.len  = bl;
            t.ch   = int'(stim[pos + bl]);
            t.last = (pos + bl + 1 == n) ? 1 : 0;
            exp_q.push_back(t);
            pos = pos + bl + 1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"},   32'(bus.in_ready),   0);
        chk({tag, "_out_valid"},  32'(bus.out_valid),  0);
        chk({tag, "_out_offset"}, 32'(bus.out_offset), 0);
        chk({tag, "_out_len"},    32'(bus.out_len),    0);
        chk({tag, "_out_char"},   32'(bus.out_char),   0);
        chk({tag, "_out_last"},   32'(bus.out_last),   0);
        chk({tag, "_done"},       32'(bus.done),       0);
    endtask

    // Streams stim into the encoder and checks every triple against the model.
    task automatic run_string(input int gap_pct, input int stall_pct, input int hold_first);
        model();
        fork
            begin : drv
                int i;
                int cyc;
                i = 0;
                cyc = 0;
                while (i < stim.size() && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (int'($urandom_range(99)) >= gap_pct) begin
                        bus.in_valid = 1'b1;
                        bus.in_char  = stim[i];
                        bus.in_last  = (i == stim.size() - 1);
                    end else begin
                        bus.in_valid = 1'b0;
                        bus.in_char  = 8'($urandom);
                        bus.in_last  = 1'($urandom);
                    end
                    if (bus.in_valid && bus.in_ready) i++;
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                chk("drv_chars_accepted", 32'(i), 32'(stim.size()));
            end
            begin : rcv
                int n;
                int cyc;
                int held;
                int seen;
                logic [3:0] s_off;
                logic [2:0] s_len;
                logic [7:0] s_ch;
                logic       s_last;
                n = 0;
                cyc = 0;
                held = 0;
                seen = 0;
                while (n < exp_q.size() && cyc < 5000) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.out_valid) begin
                        chk("in_ready_while_valid", 32'(bus.in_ready), 0);
                        if (held < hold_first) begin
                            if (held == 0) begin
                                s_off  = bus.out_offset;
                                s_len  = bus.out_len;
                                s_ch   = bus.out_char;
                                s_last = bus.out_last;
                            end else begin
                                chk("hold_offset", 32'(bus.out_offset), 32'(s_off));
                                chk("hold_len",    32'(bus.out_len),    32'(s_len));
                                chk("hold_char",   32'(bus.out_char),   32'(s_ch));
                                chk("hold_last",   32'(bus.out_last),   32'(s_last));
                            end
                            bus.out_ready = 1'b0;
                            held++;
                        end else begin
                            bus.out_ready = (int'($urandom_range(99)) >= stall_pct);
                            if (bus.out_ready) begin
                                chk("out_offset", 32'(bus.out_offset), 32'(exp_q[n].off));
                                chk("out_len",    32'(bus.out_len),    32'(exp_q[n].len));
                                chk("out_char",   32'(bus.out_char),   32'(exp_q[n].ch));
                                chk("out_last",   32'(bus.out_last),   32'(exp_q[n].last));
                                n++;
                            end
                        end
                    end else begin
                        bus.out_ready = 1'($urandom);
                    end
                end
                chk("triples_received", 32'(n), 32'(exp_q.size()));
                for (int c = 0; c < 30 && seen == 0; c++) begin
                    @(negedge clk);
                    bus.out_ready = 1'b0;
                    if (bus.done) seen = 1;
                end
                chk("done_seen", 32'(seen), 1);
                @(negedge clk);
                chk("done_one_cycle", 32'(bus.done), 0);
            end
        join
    endtask

    initial begin
        int ok;
        bus.in_valid  = 1'b0;
        bus.in_char   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        // Repeated char: self-overlap behaviour depends on the build option.
        load("0000");
        run_string(0, 0, 0);

        // Match against an older offset.
        load("01201");
        run_string(20, 20, 0);

        // Back-pressure on the first triple.
        load("0110");
        run_string(0, 0, 5);

        // Oldest chars drop out of the search window.
        load("0123456789ABCDEF0123");
        run_string(30, 30, 0);

        // Reset while searching: the partial string must vanish.
        ok = 0;
        for (int c = 0; c < 20 && ok == 0; c++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        chk("pre_reset_in_ready", 32'(ok), 1);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_char  = 8'h61 + 8'(i);
            bus.in_last  = (i == 2);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        load("5");
        run_string(0, 0, 0);

        // Random strings over a small alphabet to provoke matches.
        for (int r = 0; r < 15; r++) begin
            int len;
            len = int'($urandom_range(1, 25));
            stim.delete();
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(3))
                    0: stim.push_back(8'h30);
                    1: stim.push_back(8'h31);
                    2: stim.push_back(8'h41);
                    default: stim.push_back(8'h42);
                endcase
            end
            run_string(int'($urandom_range(40)), int'($urandom_range(40)), int'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
